// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed, XOR-checksummed program image from an
// 8-bit valid/ready byte stream into instruction memory, and holds the CPU in
// reset until a complete image with a good checksum has been written.
module imem_loader #(
    parameter int DSIZE = 16,
    parameter int ISIZE = 16,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_wen,
    output logic [ISIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_data,
    output logic             cpu_rst,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ISIZE-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic [7:0]  len_hi;    // high length byte, held until the low byte arrives
    logic [15:0] len;       // word count N of the current load
    logic [7:0]  hi_byte;   // high half of the word being assembled
    logic [7:0]  csum;      // running XOR of every byte accepted so far
    // One bit wider than N so that N = 65535 words can be counted without wrap.
    logic [16:0] wcnt;

    logic        xfer;
    logic [15:0] n_rx;
    logic [16:0] wcnt_nxt;

    assign xfer     = in_valid & in_ready;
    assign n_rx     = {len_hi, in_data};
    assign wcnt_nxt = wcnt + 17'd1;

    // Status outputs are pure decodes of the state register, so they settle
    // immediately on an asynchronous reset.
    always_comb begin
        in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                   (state == S_DATA_HI) || (state == S_DATA_LO) ||
                   (state == S_CSUM);
        busy     = in_ready;
        done     = (state == S_DONE);
        err      = (state == S_ERR);
        cpu_rst  = (state != S_DONE);
    end

    // Loader FSM: parses the byte stream, issues one-cycle word writes and
    // checks the trailing XOR checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            len_hi       <= '0;
            len          <= '0;
            hi_byte      <= '0;
            csum         <= '0;
            wcnt         <= '0;
            words_loaded <= '0;
            mem_wen      <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
        end else begin
            mem_wen <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_LEN_HI;
                        csum         <= '0;
                        wcnt         <= '0;
                        words_loaded <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_hi <= in_data;
                        csum   <= csum ^ in_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len  <= n_rx;
                        csum <= csum ^ in_data;
                        // Oversized images are rejected before any word is written.
                        if (int'(n_rx) > DEPTH)
                            state <= S_ERR;
                        else if (n_rx == 16'd0)
                            state <= S_CSUM;
                        else
                            state <= S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    if (xfer) begin
                        hi_byte <= in_data;
                        csum    <= csum ^ in_data;
                        state   <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (xfer) begin
                        mem_wen      <= 1'b1;
                        mem_addr     <= ISIZE'(wcnt);
                        mem_data     <= DSIZE'({hi_byte, in_data});
                        wcnt         <= wcnt_nxt;
                        words_loaded <= ISIZE'(wcnt_nxt);
                        csum         <= csum ^ in_data;
                        if (wcnt_nxt == {1'b0, len})
                            state <= S_CSUM;
                        else
                            state <= S_DATA_HI;
                    end
                end
                S_CSUM: begin
                    // csum already covers every byte before the checksum byte.
                    if (xfer)
                        state <= (in_data == csum) ? S_DONE : S_ERR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: drives byte-stream loads, keeps a scoreboard of
// expected memory writes and a model of the instruction memory.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_wen;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    imem_loader #(.DSIZE(16), .ISIZE(16), .DEPTH(256)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    int          tests = 0;
    int          fails = 0;
    int          wr_cnt = 0;
    wr_t         exp_q[$];
    wr_t         exp_e;
    logic [15:0] mem [0:255];
    logic [15:0] wv[$];
    bit          throttle = 0;
    bit          start_noise = 0;

    // Write monitor: every mem_wen cycle must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && mem_wen) begin
            wr_cnt++;
            mem[mem_addr[7:0]] = mem_data;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, none expected", mem_addr, mem_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({mem_addr, mem_data} !== {exp_e.addr, exp_e.data}) begin
                    fails++;
                    $display("FAIL wr_match: got addr=%h data=%h, want addr=%h data=%h",
                             mem_addr, mem_data, exp_e.addr, exp_e.data);
                end
            end
        end
    end

    // Pulse start for one sampled edge; next negedge the DUT should be in LEN_HI.
    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        tests++;
        if ({in_ready, busy, cpu_rst, done, err} !== 5'b11100) begin
            fails++;
            $display("FAIL start_state: rdy/busy/cpu_rst/done/err=%b want 11100",
                     {in_ready, busy, cpu_rst, done, err});
        end
    endtask

    // Send length n, the words in wv and a checksum xored with delta; only the
    // first max_bytes bytes go out. Expected writes are queued as LO bytes go.
    task automatic send_load(input logic [15:0] n, input logic [7:0] delta, input int max_bytes);
        logic [7:0] bs[$];
        logic [7:0] x;
        int         k;
        bs.push_back(n[15:8]);
        bs.push_back(n[7:0]);
        foreach (wv[i]) begin
            bs.push_back(wv[i][15:8]);
            bs.push_back(wv[i][7:0]);
        end
        x = 8'h00;
        foreach (bs[i]) x ^= bs[i];
        bs.push_back(x ^ delta);
        for (int i = 0; i < bs.size() && i < max_bytes; i++) begin
            if (throttle) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    if (start_noise) start = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = bs[i];
            if (start_noise) start = 1'($urandom_range(0, 1));
            k = 0;
            while (!in_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) begin
                tests++;
                fails++;
                $display("FAIL byte_timeout: byte %0d in_ready=%b want 1", i, in_ready);
                in_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            if (i >= 3 && i < bs.size() - 1 && (i % 2) == 1 && int'(n) <= 256)
                exp_q.push_back('{addr: 16'((i - 3) / 2), data: wv[(i - 3) / 2]});
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({in_ready, mem_wen, busy, done, err, cpu_rst} !== 6'b000001) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000001", {in_ready, mem_wen, busy, done, err, cpu_rst});
        end
        tests++;
        if ({mem_addr, mem_data, words_loaded} !== 48'h0) begin
            fails++;
            $display("FAIL reset_data: addr=%h data=%h wl=%h want 0", mem_addr, mem_data, words_loaded);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        tests++;
        if ({busy, cpu_rst} !== 2'b01) begin
            fails++;
            $display("FAIL idle_after_reset: busy/cpu_rst=%b want 01", {busy, cpu_rst});
        end
    endtask

    task automatic test_basic();
        int w0;
        w0 = wr_cnt;
        wv = '{16'h1234, 16'hABCD};
        do_start();
        send_load(16'd2, 8'h00, 99);
        #1;
        tests++;
        if ({done, err, cpu_rst, busy} !== 4'b1000) begin
            fails++;
            $display("FAIL basic_status: done/err/cpu_rst/busy=%b want 1000", {done, err, cpu_rst, busy});
        end
        tests++;
        if (words_loaded !== 16'd2) begin
            fails++;
            $display("FAIL basic_words: got %0d want 2", words_loaded);
        end
        tests++;
        if (wr_cnt - w0 != 2 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL basic_wr_count: got %0d writes, %0d pending, want 2 and 0", wr_cnt - w0, exp_q.size());
        end
        tests++;
        if ({mem[0], mem[1]} !== {16'h1234, 16'hABCD}) begin
            fails++;
            $display("FAIL basic_mem: got %h %h want 1234 abcd", mem[0], mem[1]);
        end
    endtask

    task automatic test_bad_csum();
        wv = '{16'h1234, 16'hABCD};
        do_start();
        send_load(16'd2, 8'h01, 99);   // checksum byte 0x43
        #1;
        tests++;
        if ({err, done, cpu_rst, busy} !== 4'b1010) begin
            fails++;
            $display("FAIL bad_csum: err/done/cpu_rst/busy=%b want 1010", {err, done, cpu_rst, busy});
        end
        do_start();
        send_load(16'd2, 8'h00, 99);
        #1;
        tests++;
        if ({done, err, cpu_rst} !== 3'b100) begin
            fails++;
            $display("FAIL reload_after_err: done/err/cpu_rst=%b want 100", {done, err, cpu_rst});
        end
    endtask

    task automatic test_len_overflow();
        int w0;
        w0 = wr_cnt;
        wv = '{};
        do_start();
        send_load(16'h0101, 8'h00, 2);
        #1;
        tests++;
        if ({err, in_ready, busy, cpu_rst, done} !== 5'b10010) begin
            fails++;
            $display("FAIL len_overflow: err/rdy/busy/cpu_rst/done=%b want 10010",
                     {err, in_ready, busy, cpu_rst, done});
        end
        repeat (3) @(negedge clk);
        tests++;
        if (wr_cnt != w0 || words_loaded !== 16'd0) begin
            fails++;
            $display("FAIL len_overflow_wr: got %0d writes wl=%0d want 0 0", wr_cnt - w0, words_loaded);
        end
    endtask

    task automatic test_zero_len();
        int w0;
        w0 = wr_cnt;
        wv = '{};
        do_start();
        send_load(16'd0, 8'h00, 99);
        #1;
        tests++;
        if ({done, err, cpu_rst} !== 3'b100 || words_loaded !== 16'd0 || wr_cnt != w0) begin
            fails++;
            $display("FAIL zero_len: done/err/cpu_rst=%b wl=%0d writes=%0d want 100 0 0",
                     {done, err, cpu_rst}, words_loaded, wr_cnt - w0);
        end
    endtask

    task automatic test_throttle();
        logic [15:0] ref_w[$];
        wv = '{};
        for (int i = 0; i < 5; i++) wv.push_back(16'($urandom));
        ref_w = wv;
        throttle    = 1;
        start_noise = 1;
        do_start();
        send_load(16'd5, 8'h00, 99);
        throttle    = 0;
        start_noise = 0;
        #1;
        tests++;
        if ({done, err, cpu_rst} !== 3'b100 || words_loaded !== 16'd5) begin
            fails++;
            $display("FAIL throttle_status: done/err/cpu_rst=%b wl=%0d want 100 5", {done, err, cpu_rst}, words_loaded);
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (mem[i] !== ref_w[i]) begin
                fails++;
                $display("FAIL throttle_mem[%0d]: got %h want %h", i, mem[i], ref_w[i]);
            end
        end
    endtask

    task automatic test_abort_reset();
        wv = '{16'h5A5A, 16'h1111, 16'h2222};
        do_start();
        send_load(16'd3, 8'h00, 4);   // length + first word only
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({in_ready, mem_wen, busy, done, err, cpu_rst} !== 6'b000001) begin
            fails++;
            $display("FAIL async_reset_ctrl: got %b want 000001", {in_ready, mem_wen, busy, done, err, cpu_rst});
        end
        tests++;
        if ({mem_addr, mem_data, words_loaded} !== 48'h0) begin
            fails++;
            $display("FAIL async_reset_data: addr=%h data=%h wl=%h want 0", mem_addr, mem_data, words_loaded);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        tests++;
        if (mem[0] !== 16'h5A5A || exp_q.size() != 0 || {busy, cpu_rst} !== 2'b01) begin
            fails++;
            $display("FAIL abort_state: mem0=%h pending=%0d busy/cpu_rst=%b want 5a5a 0 01",
                     mem[0], exp_q.size(), {busy, cpu_rst});
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_bad_csum();
        test_len_overflow();
        test_zero_len();
        test_throttle();
        test_abort_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
